// File: rtl/store_buffer_pkg.sv
// Shared widths, entry bundle and byte-lane merge helper for the store buffer.
// Optional store coalescing is enabled by defining RYSY_STB_MERGE_EN.
package store_buffer_pkg;

  localparam int REG_LEN   = 32;
  localparam int ADDR_LEN  = 32;
  localparam int WADDR_LEN = ADDR_LEN - 2;
  localparam int STB_DEPTH = 4;

  typedef struct packed {
    logic [WADDR_LEN-1:0] addr;
    logic [REG_LEN-1:0]   data;
    logic [3:0]           be;
  } stb_entry_t;

  function automatic logic [REG_LEN-1:0] stb_merge(
    input logic [REG_LEN-1:0] old_d,
    input logic [REG_LEN-1:0] new_d,
    input logic [3:0]         be
  );
    logic [REG_LEN-1:0] r;
    r = old_d;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_d[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Store-side, load-hazard and data-bus signals of the store buffer.
// slave is the buffer itself; master is the core / memory side.
interface store_buffer_if #(
  parameter int ADDR_LEN = 32
) ();
  import store_buffer_pkg::*;

  localparam int AW = ADDR_LEN - 2;

  logic               st_valid;
  logic [AW-1:0]      st_addr;
  logic [REG_LEN-1:0] st_wdata;
  logic [3:0]         st_be;
  logic               st_ready;
  logic [AW-1:0]      ld_addr;
  logic               ld_hazard;
  logic               bus_req;
  logic [AW-1:0]      bus_addr;
  logic [REG_LEN-1:0] bus_wdata;
  logic [3:0]         bus_be;
  logic               bus_gnt;
  logic               empty;

  modport slave (
    input  st_valid, st_addr, st_wdata, st_be,
    input  ld_addr, bus_gnt,
    output st_ready, ld_hazard, empty,
    output bus_req, bus_addr, bus_wdata, bus_be
  );

  modport master (
    output st_valid, st_addr, st_wdata, st_be,
    output ld_addr, bus_gnt,
    input  st_ready, ld_hazard, empty,
    input  bus_req, bus_addr, bus_wdata, bus_be
  );

endinterface

// File: rtl/store_buffer_match.sv
// Valid-masked word-address comparator over all buffer slots.
// Produces one hit bit per slot.
module stb_match #(
  parameter int DEPTH = 4,
  parameter int AW    = 30
) (
  input  logic [AW-1:0]    addr_i [DEPTH],
  input  logic [DEPTH-1:0] valid_i,
  input  logic [AW-1:0]    key_i,
  output logic [DEPTH-1:0] hit_o
);

  always_comb begin
    hit_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_o[i] = valid_i[i] && (addr_i[i] == key_i);
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-store FIFO draining to the data bus, with load-hazard detection.
// Define RYSY_STB_MERGE_EN to coalesce same-word stores into the tail entry.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH    = STB_DEPTH,
  parameter int ADDR_LEN = 32
) (
  input  logic           clk,
  input  logic           rst,
  store_buffer_if.slave  sb
);

  localparam int AW = ADDR_LEN - 2;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]      rd_q, rd_d;
  logic [PW-1:0]      wr_q, wr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [AW-1:0]      addr_q [DEPTH];
  logic [REG_LEN-1:0] data_q [DEPTH];
  logic [3:0]         be_q   [DEPTH];
  logic               full;
  logic               push;
  logic               pop;
  logic               merge_hit;
  logic [DEPTH-1:0]   valid;
  logic [DEPTH-1:0]   hit;

  assign full = (cnt_q == CW'(DEPTH));

`ifdef RYSY_STB_MERGE_EN
  logic [PW-1:0] tail;
  assign tail = wr_q - PW'(1);
  // count >= 2 keeps the tail away from the head on the bus
  assign merge_hit = sb.st_valid
                   && (cnt_q >= CW'(2))
                   && (addr_q[tail] == sb.st_addr);
`else
  assign merge_hit = 1'b0;
`endif

  assign sb.st_ready  = ~full | merge_hit;
  assign push         = sb.st_valid & sb.st_ready & ~merge_hit;
  assign sb.bus_req   = (cnt_q != '0);
  assign sb.empty     = (cnt_q == '0);
  assign pop          = sb.bus_req & sb.bus_gnt;
  assign sb.bus_addr  = addr_q[rd_q];
  assign sb.bus_wdata = data_q[rd_q];
  assign sb.bus_be    = be_q[rd_q];

  always_comb begin
    valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PW-1:0] off;
      off      = PW'(i) - rd_q;
      valid[i] = ({1'b0, off} < cnt_q);
    end
  end

  stb_match #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_match (
    .addr_i  (addr_q),
    .valid_i (valid),
    .key_i   (sb.ld_addr),
    .hit_o   (hit)
  );

  assign sb.ld_hazard = |hit;

  always_comb begin
    rd_d  = pop  ? rd_q + PW'(1) : rd_q;
    wr_d  = push ? wr_q + PW'(1) : wr_q;
    cnt_d = cnt_q;
    unique case (1'b1)
      push & ~pop: cnt_d = cnt_q + CW'(1);
      pop & ~push: cnt_d = cnt_q - CW'(1);
      default:     cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_q] <= sb.st_addr;
      data_q[wr_q] <= sb.st_wdata;
      be_q[wr_q]   <= sb.st_be;
    end
`ifdef RYSY_STB_MERGE_EN
    else if (merge_hit) begin
      data_q[tail] <= stb_merge(data_q[tail], sb.st_wdata, sb.st_be);
      be_q[tail]   <= be_q[tail] | sb.st_be;
    end
`endif
  end

endmodule

// File: tb/tb_store_buffer.sv
// Table-driven and scoreboard bench for store_buffer.
// Expected merge behaviour follows RYSY_STB_MERGE_EN.
module tb_store_buffer;
  import store_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  store_buffer_if #(.ADDR_LEN(32)) sbi ();

  store_buffer #(
    .DEPTH    (4),
    .ADDR_LEN (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sbi)
  );

  typedef struct {
    logic        v;
    logic [29:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic        g;
    logic [29:0] ld;
    logic        rdy;
    logic        req;
    logic        emp;
    logic        haz;
  } vec_t;

  int ncmp = 0;
  int nerr = 0;
  stb_entry_t exp_q[$];
  vec_t tv[19];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic vec_t mk(logic v, logic [29:0] a, logic [31:0] d,
                              logic [3:0] be, logic g, logic [29:0] ld,
                              logic rdy, logic req, logic emp, logic haz);
    vec_t t;
    t.v = v; t.a = a; t.d = d; t.be = be; t.g = g; t.ld = ld;
    t.rdy = rdy; t.req = req; t.emp = emp; t.haz = haz;
    return t;
  endfunction

  // scoreboard: every granted bus write must match the oldest expected store
  always @(negedge clk) begin
    if (!rst && sbi.bus_req && sbi.bus_gnt) begin
      if (exp_q.size() == 0) begin
        ncmp++;
        nerr++;
        $display("FAIL unexpected_write: addr %0h with empty scoreboard at %0t",
                 sbi.bus_addr, $time);
      end else begin
        stb_entry_t e;
        e = exp_q.pop_front();
        chk("bus_addr", 64'(sbi.bus_addr), 64'(e.addr));
        chk("bus_wdata", 64'(sbi.bus_wdata), 64'(e.data));
        chk("bus_be", 64'(sbi.bus_be), 64'(e.be));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, logic [29:0] a, logic [31:0] d,
                       logic [3:0] be, logic g);
    sbi.st_valid = v;
    sbi.st_addr  = a;
    sbi.st_wdata = d;
    sbi.st_be    = be;
    sbi.bus_gnt  = g;
  endtask

  task automatic expect_push(logic [29:0] a, logic [31:0] d, logic [3:0] be);
    stb_entry_t e;
    e.addr = a;
    e.data = d;
    e.be   = be;
    exp_q.push_back(e);
  endtask

  task automatic chk_flags(string tag, logic rdy, logic req, logic emp, logic haz);
    chk({tag, ".st_ready"}, 64'(sbi.st_ready), 64'(rdy));
    chk({tag, ".bus_req"}, 64'(sbi.bus_req), 64'(req));
    chk({tag, ".empty"}, 64'(sbi.empty), 64'(emp));
    chk({tag, ".ld_hazard"}, 64'(sbi.ld_hazard), 64'(haz));
  endtask

  initial begin
    bit merge;
`ifdef RYSY_STB_MERGE_EN
    merge = 1'b1;
`else
    merge = 1'b0;
`endif
    //            v  addr    wdata         be     g  ld      rdy req emp haz
    tv[0]  = mk(1, 'h40,  'h00000078, 4'b0001, 1, 'h40,  1, 0, 1, 0);
    tv[1]  = mk(0, 'h0,   'h0,        4'b0000, 1, 'h40,  1, 1, 0, 1);
    tv[2]  = mk(0, 'h0,   'h0,        4'b0000, 0, 'h40,  1, 0, 1, 0);
    tv[3]  = mk(1, 'h100, 'h11111111, 4'b1111, 0, 'h100, 1, 0, 1, 0);
    tv[4]  = mk(1, 'h101, 'h22222222, 4'b0011, 0, 'h100, 1, 1, 0, 1);
    tv[5]  = mk(1, 'h102, 'h33333333, 4'b1100, 0, 'h41,  1, 1, 0, 0);
    tv[6]  = mk(1, 'h103, 'h44444444, 4'b0101, 0, 'h103, 1, 1, 0, 0);
    tv[7]  = mk(1, 'h104, 'h55555555, 4'b1111, 0, 'h103, 0, 1, 0, 1);
    tv[8]  = mk(1, 'h104, 'h55555555, 4'b1111, 1, 'h103, 0, 1, 0, 1);
    tv[9]  = mk(1, 'h104, 'h55555555, 4'b1111, 1, 'h100, 1, 1, 0, 0);
    tv[10] = mk(0, 'h0,   'h0,        4'b0000, 1, 'h104, 1, 1, 0, 1);
    tv[11] = mk(0, 'h0,   'h0,        4'b0000, 1, 'h104, 1, 1, 0, 1);
    tv[12] = mk(0, 'h0,   'h0,        4'b0000, 1, 'h104, 1, 1, 0, 1);
    tv[13] = mk(0, 'h0,   'h0,        4'b0000, 1, 'h104, 1, 0, 1, 0);
    tv[14] = mk(1, 'h200, 'hA5A5A5A5, 4'b1111, 0, 'h200, 1, 0, 1, 0);
    tv[15] = mk(1, 'h201, 'h5A5A5A5A, 4'b0110, 1, 'h201, 1, 1, 0, 0);
    tv[16] = mk(0, 'h0,   'h0,        4'b0000, 0, 'h201, 1, 1, 0, 1);
    tv[17] = mk(0, 'h0,   'h0,        4'b0000, 1, 'h200, 1, 1, 0, 0);
    tv[18] = mk(0, 'h0,   'h0,        4'b0000, 0, 'h201, 1, 0, 1, 0);

    drive(0, '0, '0, '0, 0);
    sbi.ld_addr = '0;
    rst = 1'b1;
    step();
    step();
    chk_flags("reset", 1, 0, 1, 0);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      drive(tv[i].v, tv[i].a, tv[i].d, tv[i].be, tv[i].g);
      sbi.ld_addr = tv[i].ld;
      if (tv[i].v && tv[i].rdy) expect_push(tv[i].a, tv[i].d, tv[i].be);
      #1;
      chk_flags($sformatf("vec%0d", i), tv[i].rdy, tv[i].req, tv[i].emp, tv[i].haz);
      step();
    end
    chk("table_drained", 64'(exp_q.size()), 64'(0));

    // reset with three stores queued: they must be discarded
    drive(1, 'h300, 'hDEADBEEF, 4'b1111, 0);
    step();
    drive(1, 'h301, 'hCAFEF00D, 4'b1111, 0);
    step();
    drive(1, 'h302, 'h0BADC0DE, 4'b1111, 0);
    step();
    drive(0, '0, '0, '0, 0);
    sbi.ld_addr = 'h300;
    #1;
    chk_flags("pre_rst", 1, 1, 0, 1);
    rst = 1'b1;
    #1;
    chk_flags("async_rst", 1, 0, 1, 0);
    step();
    rst = 1'b0;
    sbi.bus_gnt = 1'b1;
    #1;
    chk_flags("post_rst", 1, 0, 1, 0);
    step();
    step();
    step();
    chk("post_rst_empty", 64'(sbi.empty), 64'(1));

    // same-word stores: coalesced into the tail when merging is built in
    drive(1, 'h10, 'h12345678, 4'b1111, 0);
    expect_push('h10, 'h12345678, 4'b1111);
    step();
    drive(1, 'h20, 'h00000078, 4'b0001, 0);
    if (!merge) expect_push('h20, 'h00000078, 4'b0001);
    step();
    drive(1, 'h20, 'h56780000, 4'b1100, 0);
    if (merge) expect_push('h20, 'h56780078, 4'b1101);
    else expect_push('h20, 'h56780000, 4'b1100);
    #1;
    chk("merge_st_ready", 64'(sbi.st_ready), 64'(1));
    step();
    drive(0, '0, '0, '0, 1);
    step();
    step();
    chk("merge_count_empty", 64'(sbi.empty), 64'(merge));
    step();
    chk("merge_final_empty", 64'(sbi.empty), 64'(1));
    chk("merge_drained", 64'(exp_q.size()), 64'(0));

    drive(0, '0, '0, '0, 0);
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-store buffer sitting directly downstream of `select_wr`. It accepts byte-aligned store data and byte enables from the execute stage and queues them in a small FIFO. It drains the queue to the data-memory bus with a request/grant handshake, so stores never stall the core unless the buffer is full. It also flags loads whose word address matches a pending store, so the core can stall until that store has drained.

## Interface
Parameters:
- `DEPTH`, 4, number of entries; power of two, ≥2.
- `ADDR_LEN`, 32, byte-address width; the block stores word addresses of width `ADDR_LEN-2`.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `st_valid` in 1: a store is presented this cycle.
- `st_addr` in `ADDR_LEN-2`: store word address.
- `st_wdata` in `REG_LEN`: lane-aligned data from `select_wr.wdata`.
- `st_be` in 4: byte enables from `select_wr.be`.
- `st_ready` out 1: the store is accepted when `st_valid & st_ready`.
- `ld_addr` in `ADDR_LEN-2`: word address of the current load.
- `ld_hazard` out 1: combinational; high when any valid entry has word address equal to `ld_addr`.
- `bus_req` out 1: head entry is valid.
- `bus_addr` out `ADDR_LEN-2`: head word address.
- `bus_wdata` out `REG_LEN`: head data.
- `bus_be` out 4: head byte enables.
- `bus_gnt` in 1: the head is written when `bus_req & bus_gnt`.
- `empty` out 1: no valid entries; used by fence/halt logic.

## Operation
- Circular FIFO with read pointer `rd_ptr`, write pointer `wr_ptr` and occupancy counter `count` (width clog2(DEPTH)+1).
- Push when `st_valid & st_ready`: write {addr, wdata, be} at `wr_ptr`; increment `wr_ptr` modulo DEPTH.
- Pop when `bus_req & bus_gnt`: increment `rd_ptr` modulo DEPTH.
- Counter update:
  - push & pop in the same cycle: `count` unchanged.
  - push only: `count` +1.
  - pop only: `count` −1.
- `st_ready = (count != DEPTH)`. No push-on-pop when full; `st_ready` depends only on registered state.
- `bus_req = (count != 0)`. `bus_*` are driven directly from the head slot.
  - Head fields are stable while `bus_req=1` and `bus_gnt=0`.
- `empty = (count == 0)`.
- Hazard compare: `ld_hazard` covers only valid entries (between `rd_ptr` and `count`).
  - It does not cover a store being pushed in the same cycle.
  - It includes the head even while it is being granted.
- Entry data registers are not reset; only the pointers and the counter are.
- Reset mid-operation discards all pending stores.

## Timing
- Reset values: `bus_req=0`, `st_ready=1`, `empty=1`, `ld_hazard=0`, `count=0`, both pointers 0.
  - `bus_addr`, `bus_wdata` and `bus_be` show slot 0 contents (don't-care while `bus_req=0`).
- Latency:
  - A store pushed at edge N appears at the bus at N+1 if the buffer was empty.
  - With `bus_gnt=1` it leaves at edge N+1; `empty` returns to 1 after that edge.
- Throughput: one push and one pop per cycle.
- Full boundary: at `count=DEPTH`, `st_ready=0` even if `bus_gnt=1` that cycle; it rises the cycle after the pop.
- Empty boundary: `bus_gnt` is ignored while `bus_req=0`.
- Pointer wrap: DEPTH−1 → 0.

## Configuration
- `RYSY_STB_MERGE_EN` defined: store merging (coalescing) is enabled.
  - Condition: a presented store whose `st_addr` equals the tail entry's address, with `count ≥ 2` (so the tail is never the head on the bus).
  - Action: the store merges into the tail. For each lane with `st_be[i]=1`, tail byte i takes `st_wdata` byte i. Tail `be` becomes the OR of the old and new enables. Pointers and `count` are unchanged.
  - Merging is accepted even when full: `st_ready = (count != DEPTH) | merge_hit`.
- Undefined: every accepted store allocates a new entry.

## Structure
- Add to `rysyPkg`:
  - `STB_DEPTH` (default 4).
  - Packed struct `stb_entry_t` {word addr, `REG_LEN` data, 4-bit be}.
- Sub-module `stb_match`: parameterized, valid-masked address comparator. It returns a DEPTH-bit hit vector, reduced to `ld_hazard`.
- Everything else lives in `store_buffer`.

## Test plan
- Reset mid-stream with 3 entries queued → next cycle `bus_req=0`, `st_ready=1`, `empty=1`; nothing is written after reset.
- `bus_gnt=1`; push addr 0x40, wdata 0x00000078, be 0001 → next cycle `bus_req=1`, `bus_addr=0x40`, `bus_wdata=0x00000078`, `bus_be=0001`; following cycle `empty=1`.
- `bus_gnt=0`; push 4 distinct stores → `st_ready=0` after the 4th, and a 5th held on `st_valid` is not accepted. Raise `bus_gnt` → entries drain in push order, one per cycle; the 5th is accepted the cycle after the first pop.
- One entry at addr 0x40 pending:
  - `ld_addr=0x40` → `ld_hazard=1`.
  - `ld_addr=0x41` → `ld_hazard=0`.
  - After the entry drains, `ld_addr=0x40` → `ld_hazard=0`.
- `count=1`, simultaneous push and grant → `count` stays 1; the bus shows the new entry next cycle.
- `bus_gnt=0`; push addr 0x10 be 1111 wdata 0x12345678, then addr 0x20 be 0001 wdata 0x00000078, then addr 0x20 be 1100 wdata 0x56780000:
  - With `RYSY_STB_MERGE_EN`: `count=2`; the second entry drains as wdata 0x56780078, be 1101.
  - Without it: `count=3`; the entries drain unchanged.
